// File: rtl/inst_buffer_ctrl_if.sv
// Handshake/bus bundle between decode, the instruction-buffer controller and dispatch.
// The perf counter outputs exist only when INST_BUFFER_CTRL_PERF_EN is defined.
interface inst_buffer_ctrl_if #(
  parameter int DEPTH_LOG = 5,
  parameter int FETCH_W   = 8,
  parameter int DISP_W    = 4
);
  logic                           flush_i;
  logic                           stall_i;
  logic                           decodeReady_i;
  logic [FETCH_W-1:0]             decodedVector_i;
  logic [FETCH_W-1:0]             writeEnable_o;
  logic [FETCH_W*DEPTH_LOG-1:0]   writeAddr_o;
  logic [DISP_W*DEPTH_LOG-1:0]    readAddr_o;
  logic                           instBufferReady_o;
  logic                           stallFetch_o;
  logic [DEPTH_LOG:0]             instCount_o;
  logic                           flushBusy_o;
`ifdef INST_BUFFER_CTRL_PERF_EN
  logic [31:0]                    perfFullCyc_o;
  logic [DEPTH_LOG:0]             perfHighWater_o;
`endif

  // Decode/dispatch side: drives requests, observes the controller.
  modport master (
    output flush_i, stall_i, decodeReady_i, decodedVector_i,
    input  writeEnable_o, writeAddr_o, readAddr_o, instBufferReady_o,
           stallFetch_o, instCount_o, flushBusy_o
`ifdef INST_BUFFER_CTRL_PERF_EN
    , input perfFullCyc_o, perfHighWater_o
`endif
  );

  // Controller side.
  modport slave (
    input  flush_i, stall_i, decodeReady_i, decodedVector_i,
    output writeEnable_o, writeAddr_o, readAddr_o, instBufferReady_o,
           stallFetch_o, instCount_o, flushBusy_o
`ifdef INST_BUFFER_CTRL_PERF_EN
    , output perfFullCyc_o, perfHighWater_o
`endif
  );
endinterface

// File: rtl/inst_buffer_ctrl.sv
// Instruction-buffer pointer/occupancy controller: owns head/tail pointers and the
// instruction count, generates SRAM write enables/addresses and read addresses, and
// sequences flush recovery. Optional perf counters: define INST_BUFFER_CTRL_PERF_EN.
module inst_buffer_ctrl #(
  parameter int DEPTH       = 32,
  parameter int DEPTH_LOG   = 5,
  parameter int FETCH_W     = 8,
  parameter int DISP_W      = 4,
  parameter int RECOVER_CYC = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  inst_buffer_ctrl_if.slave     bus
);

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  localparam int              REC_W    = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
  localparam logic [REC_W-1:0] REC_LAST = REC_W'(RECOVER_CYC - 1);
  localparam int              CNT_W    = DEPTH_LOG + 1;

  state_t                r_state;
  logic [REC_W-1:0]      r_recCnt;
  logic [DEPTH_LOG-1:0]  r_head;
  logic [DEPTH_LOG-1:0]  r_tail;
  logic [CNT_W-1:0]      r_count;

  state_t                w_stateNext;
  logic [REC_W-1:0]      w_recCntNext;
  logic [DEPTH_LOG-1:0]  w_headNext;
  logic [DEPTH_LOG-1:0]  w_tailNext;
  logic [CNT_W-1:0]      w_countNext;
  logic [CNT_W-1:0]      w_slots;
  logic [CNT_W-1:0]      w_push;
  logic [CNT_W-1:0]      w_pop;
  logic                  w_stallFetch;
  logic                  w_ready;
  logic                  w_pushEn;
  logic                  w_popEn;

  assign w_stallFetch = (r_count > CNT_W'(DEPTH - FETCH_W)) | (r_state == RECOVER);
  assign w_ready      = (r_count >= CNT_W'(DISP_W)) & (r_state == RUN);

  // Reset gating keeps write enables low while reset is held, even with decode active.
  assign w_pushEn = reset & bus.decodeReady_i & ~w_stallFetch & (r_state == RUN) & ~bus.flush_i;
  assign w_popEn  = reset & w_ready & ~bus.stall_i & ~bus.flush_i;
  assign w_push   = w_pushEn ? w_slots : '0;
  assign w_pop    = w_popEn ? CNT_W'(DISP_W) : '0;

  // Count valid decode slots; the vector is contiguous from bit 0.
  always_comb begin
    w_slots = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      w_slots = w_slots + CNT_W'(bus.decodedVector_i[k]);
    end
  end

  // Per-port write enables/addresses from the tail and read addresses from the head.
  always_comb begin
    bus.writeEnable_o = '0;
    bus.writeAddr_o   = '0;
    bus.readAddr_o    = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      bus.writeEnable_o[k]                       = (CNT_W'(k) < w_push);
      bus.writeAddr_o[k*DEPTH_LOG +: DEPTH_LOG]  = r_tail + DEPTH_LOG'(k);
    end
    for (int k = 0; k < DISP_W; k++) begin
      bus.readAddr_o[k*DEPTH_LOG +: DEPTH_LOG]   = r_head + DEPTH_LOG'(k);
    end
  end

  assign bus.instBufferReady_o = w_ready;
  assign bus.stallFetch_o      = w_stallFetch;
  assign bus.instCount_o       = r_count;
  assign bus.flushBusy_o       = (r_state == RECOVER);

  // Pointer/count next values; a flush discards this cycle's traffic and empties the buffer.
  always_comb begin
    w_headNext  = r_head + w_pop[DEPTH_LOG-1:0];
    w_tailNext  = r_tail + w_push[DEPTH_LOG-1:0];
    w_countNext = r_count + w_push - w_pop;
    if (bus.flush_i) begin
      w_headNext  = '0;
      w_tailNext  = '0;
      w_countNext = '0;
    end
  end

  // Recovery FSM next state: quiet for RECOVER_CYC cycles, restarted by any new flush.
  always_comb begin
    w_stateNext  = r_state;
    w_recCntNext = r_recCnt;
    case (r_state)
      RUN: begin
        if (bus.flush_i) begin
          w_stateNext  = RECOVER;
          w_recCntNext = '0;
        end
      end
      RECOVER: begin
        if (bus.flush_i) begin
          w_recCntNext = '0;
        end else if (r_recCnt == REC_LAST) begin
          w_stateNext  = RUN;
          w_recCntNext = '0;
        end else begin
          w_recCntNext = r_recCnt + 1'b1;
        end
      end
      default: begin
        w_stateNext  = RUN;
        w_recCntNext = '0;
      end
    endcase
  end

  // State, pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= RUN;
      r_recCnt <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_recCnt <= w_recCntNext;
      r_head   <= w_headNext;
      r_tail   <= w_tailNext;
      r_count  <= w_countNext;
    end
  end

`ifdef INST_BUFFER_CTRL_PERF_EN
  logic [31:0]      r_perfFullCyc;
  logic [CNT_W-1:0] r_perfHighWater;

  // Full-cycle counter saturates; high-water tracks the largest occupancy seen. Flush does not clear them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perfFullCyc   <= '0;
      r_perfHighWater <= '0;
    end else begin
      if (w_stallFetch && (r_state == RUN) && (r_perfFullCyc != 32'hFFFF_FFFF)) begin
        r_perfFullCyc <= r_perfFullCyc + 32'd1;
      end
      if (w_countNext > r_perfHighWater) begin
        r_perfHighWater <= w_countNext;
      end
    end
  end

  assign bus.perfFullCyc_o   = r_perfFullCyc;
  assign bus.perfHighWater_o = r_perfHighWater;
`endif

endmodule
